// File: rtl/check_fmps_test_link.sv
// check_fmps_test_link
// Receive-side checker for the FMPS test link. Consumes two-word test packets
// (header, then data with tlast) from the Aurora RX AXI-Stream and validates
// framing, header magic, FMPS index sequencing and the per-session cycle
// counter. One status strobe/code is reported per packet or framing event, and
// saturating packet/error counters are kept for CSR readback.

module check_fmps_test_link #(
   parameter logic [15:0] HEADER_MAGIC           = 16'hB6CF,
   parameter string       WITH_MULT_PACK_SUPPORT = "false",
   parameter int          MAX_FMPSS              = 32,
   localparam int         FMPS_INDEX_WIDTH       = $clog2(MAX_FMPSS)
) (
   input  logic                        auroraUserClk,
   input  logic                        auroraUserRstN,
   input  logic                        auroraFAstrobe,
   input  logic [31:0]                 FMPS_TEST_AXI_STREAM_RX_tdata,
   input  logic                        FMPS_TEST_AXI_STREAM_RX_tvalid,
   input  logic                        FMPS_TEST_AXI_STREAM_RX_tlast,
   output logic                        FMPS_TEST_AXI_STREAM_RX_tready,
   output logic                        statusStrobe,
   output logic [1:0]                  statusCode,
   output logic [FMPS_INDEX_WIDTH-1:0] lastIndex,
   output logic [7:0]                  lastCycleCount,
   output logic [15:0]                 packetCount,
   output logic [15:0]                 errorCount
);

   // Index sequencing is only enforced when multi-packet support is enabled;
   // the parameter is accepted in either lower or upper case.
   localparam bit MULT_PACK = (WITH_MULT_PACK_SUPPORT == "true") ||
                              (WITH_MULT_PACK_SUPPORT == "TRUE");

   localparam logic [1:0] CODE_OK      = 2'd0;
   localparam logic [1:0] CODE_BAD_HDR = 2'd1;
   localparam logic [1:0] CODE_BAD_DAT = 2'd2;
   localparam logic [1:0] CODE_FRAMING = 2'd3;

   localparam logic [FMPS_INDEX_WIDTH-1:0] INDEX_ONE = 1;

   typedef enum logic [1:0] {
      ST_HEADER,
      ST_DATA,
      ST_DROP
   } state_t;

   state_t                      stateQ, stateD;
   logic                        readyQ;
   logic                        statusStrobeQ, statusStrobeD;
   logic [1:0]                  statusCodeQ, statusCodeD;
   logic [FMPS_INDEX_WIDTH-1:0] lastIndexQ, lastIndexD;
   logic [7:0]                  lastCycleCountQ, lastCycleCountD;
   logic [15:0]                 packetCountQ, packetCountD;
   logic [15:0]                 errorCountQ, errorCountD;
   logic [FMPS_INDEX_WIDTH-1:0] hdrIndexQ, hdrIndexD;
   logic [7:0]                  expectedQ, expectedD;
   logic                        syncedQ, syncedD;
   logic                        firstInSessionQ, firstInSessionD;

   logic                        beatAccepted;
   logic [31:0]                 rxWord;
   logic                        headerOk;
   logic [FMPS_INDEX_WIDTH-1:0] rxHdrIndex;
   logic [FMPS_INDEX_WIDTH-1:0] rxDataIndex;
   logic [7:0]                  rxCount;
   logic                        dataFieldsOk;
   logic [FMPS_INDEX_WIDTH-1:0] nextIndex;
   logic                        indexViolation;
   logic                        counterViolation;
   logic                        reportValid;
   logic [1:0]                  reportCode;

   assign rxWord       = FMPS_TEST_AXI_STREAM_RX_tdata;
   assign beatAccepted = FMPS_TEST_AXI_STREAM_RX_tvalid && readyQ;

   // Field decode of the current beat, interpreted both as a header and as a
   // data word; the state machine decides which interpretation applies.
   assign headerOk     = (rxWord[31:16] == HEADER_MAGIC) && rxWord[15] &&
                         (rxWord[9:0] == 10'd0);
   assign rxHdrIndex   = rxWord[10 +: FMPS_INDEX_WIDTH];
   assign rxDataIndex  = rxWord[24 +: FMPS_INDEX_WIDTH];
   assign rxCount      = rxWord[7:0];
   assign dataFieldsOk = (rxWord[31:29] == 3'd0) && (rxDataIndex == hdrIndexQ) &&
                         (rxWord[23:8] == 16'hCACA);

   // The previous OK index plus one wraps naturally at the index width.
   assign nextIndex        = lastIndexQ + INDEX_ONE;
   assign indexViolation   = MULT_PACK && !firstInSessionQ && (hdrIndexQ != nextIndex);
   assign counterViolation = syncedQ && (rxCount != expectedQ);

   // Next-state computation: parse the accepted beat against the pre-strobe
   // expectations first, then layer the session-strobe effects on top so a
   // coincident strobe only influences later packets.
   always_comb begin
      stateD          = stateQ;
      statusStrobeD   = 1'b0;
      statusCodeD     = statusCodeQ;
      lastIndexD      = lastIndexQ;
      lastCycleCountD = lastCycleCountQ;
      packetCountD    = packetCountQ;
      errorCountD     = errorCountQ;
      hdrIndexD       = hdrIndexQ;
      expectedD       = expectedQ;
      syncedD         = syncedQ;
      firstInSessionD = firstInSessionQ;
      reportValid     = 1'b0;
      reportCode      = CODE_OK;

      if (beatAccepted) begin
         case (stateQ)
            ST_HEADER: begin
               if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                  reportValid = 1'b1;
                  reportCode  = CODE_FRAMING;
               end else if (!headerOk) begin
                  reportValid = 1'b1;
                  reportCode  = CODE_BAD_HDR;
                  stateD      = ST_DROP;
               end else begin
                  hdrIndexD = rxHdrIndex;
                  stateD    = ST_DATA;
               end
            end
            ST_DATA: begin
               if (!FMPS_TEST_AXI_STREAM_RX_tlast) begin
                  reportValid = 1'b1;
                  reportCode  = CODE_FRAMING;
                  stateD      = ST_DROP;
               end else begin
                  stateD      = ST_HEADER;
                  reportValid = 1'b1;
                  if (!dataFieldsOk || indexViolation || counterViolation) begin
                     reportCode = CODE_BAD_DAT;
                     if (dataFieldsOk && counterViolation) begin
                        expectedD = rxCount;
                     end
                  end else begin
                     reportCode      = CODE_OK;
                     lastIndexD      = hdrIndexQ;
                     lastCycleCountD = rxCount;
                     expectedD       = rxCount;
                     syncedD         = 1'b1;
                     firstInSessionD = 1'b0;
                     if (packetCountQ != 16'hFFFF) begin
                        packetCountD = packetCountQ + 16'd1;
                     end
                  end
               end
            end
            ST_DROP: begin
               if (FMPS_TEST_AXI_STREAM_RX_tlast) begin
                  stateD = ST_HEADER;
               end
            end
            default: begin
               stateD = ST_HEADER;
            end
         endcase
      end

      if (reportValid) begin
         statusStrobeD = 1'b1;
         statusCodeD   = reportCode;
         if ((reportCode != CODE_OK) && (errorCountQ != 16'hFFFF)) begin
            errorCountD = errorCountQ + 16'd1;
         end
      end

      if (auroraFAstrobe) begin
         firstInSessionD = 1'b1;
         if (syncedQ) begin
            expectedD = expectedD + 8'd1;
         end
      end
   end

   // State and registered outputs; reset returns everything to its idle value
   // immediately so a half-received packet is forgotten.
   always_ff @(posedge auroraUserClk or negedge auroraUserRstN) begin
      if (!auroraUserRstN) begin
         stateQ          <= ST_HEADER;
         readyQ          <= 1'b0;
         statusStrobeQ   <= 1'b0;
         statusCodeQ     <= CODE_OK;
         lastIndexQ      <= '0;
         lastCycleCountQ <= 8'd0;
         packetCountQ    <= 16'd0;
         errorCountQ     <= 16'd0;
         hdrIndexQ       <= '0;
         expectedQ       <= 8'd0;
         syncedQ         <= 1'b0;
         firstInSessionQ <= 1'b1;
      end else begin
         stateQ          <= stateD;
         readyQ          <= 1'b1;
         statusStrobeQ   <= statusStrobeD;
         statusCodeQ     <= statusCodeD;
         lastIndexQ      <= lastIndexD;
         lastCycleCountQ <= lastCycleCountD;
         packetCountQ    <= packetCountD;
         errorCountQ     <= errorCountD;
         hdrIndexQ       <= hdrIndexD;
         expectedQ       <= expectedD;
         syncedQ         <= syncedD;
         firstInSessionQ <= firstInSessionD;
      end
   end

   assign FMPS_TEST_AXI_STREAM_RX_tready = readyQ;
   assign statusStrobe                   = statusStrobeQ;
   assign statusCode                     = statusCodeQ;
   assign lastIndex                      = lastIndexQ;
   assign lastCycleCount                 = lastCycleCountQ;
   assign packetCount                    = packetCountQ;
   assign errorCount                     = errorCountQ;

endmodule

// File: tb/tb_check_fmps_test_link.sv
// Testbench for check_fmps_test_link. Two instances share one stimulus stream:
// dutA with index sequencing disabled and dutB with it enabled. Expected
// status codes are queued per instance as beats are driven and compared as
// the status strobes appear.

module tb_check_fmps_test_link;

   logic        clock;
   logic        resetN;
   logic        faStrobe;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;

   logic        treadyA, treadyB;
   logic        strobeA, strobeB;
   logic [1:0]  codeA, codeB;
   logic [4:0]  lastIndexA, lastIndexB;
   logic [7:0]  lastCycleA, lastCycleB;
   logic [15:0] packetCountA, packetCountB;
   logic [15:0] errorCountA, errorCountB;

   logic [1:0]  qA[$];
   logic [1:0]  qB[$];

   int checks;
   int errors;

   check_fmps_test_link dutA (
      .auroraUserClk                  (clock),
      .auroraUserRstN                 (resetN),
      .auroraFAstrobe                 (faStrobe),
      .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
      .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
      .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
      .FMPS_TEST_AXI_STREAM_RX_tready (treadyA),
      .statusStrobe                   (strobeA),
      .statusCode                     (codeA),
      .lastIndex                      (lastIndexA),
      .lastCycleCount                 (lastCycleA),
      .packetCount                    (packetCountA),
      .errorCount                     (errorCountA)
   );

   check_fmps_test_link #(.WITH_MULT_PACK_SUPPORT("true")) dutB (
      .auroraUserClk                  (clock),
      .auroraUserRstN                 (resetN),
      .auroraFAstrobe                 (faStrobe),
      .FMPS_TEST_AXI_STREAM_RX_tdata  (tdata),
      .FMPS_TEST_AXI_STREAM_RX_tvalid (tvalid),
      .FMPS_TEST_AXI_STREAM_RX_tlast  (tlast),
      .FMPS_TEST_AXI_STREAM_RX_tready (treadyB),
      .statusStrobe                   (strobeB),
      .statusCode                     (codeB),
      .lastIndex                      (lastIndexB),
      .lastCycleCount                 (lastCycleB),
      .packetCount                    (packetCountB),
      .errorCount                     (errorCountB)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] hdr(input logic [4:0] idx);
      return {16'hB6CF, 1'b1, idx, 10'd0};
   endfunction

   function automatic logic [31:0] dat(input logic [4:0] idx, input logic [7:0] cnt);
      return {3'b000, idx, 16'hCACA, cnt};
   endfunction

   // Advance to the next falling edge and score any status strobe seen there
   task automatic stepCycle();
      logic [1:0] exp;
      @(negedge clock);
      if (strobeA) begin
         checks++;
         if (qA.size() == 0) begin
            errors++;
            $display("[TB] FAIL strobeA unexpected: actual code=%0d required=no strobe", codeA);
         end else begin
            exp = qA.pop_front();
            if (codeA !== exp) begin
               errors++;
               $display("[TB] FAIL codeA: actual=%0d required=%0d", codeA, exp);
            end
         end
      end
      if (strobeB) begin
         checks++;
         if (qB.size() == 0) begin
            errors++;
            $display("[TB] FAIL strobeB unexpected: actual code=%0d required=no strobe", codeB);
         end else begin
            exp = qB.pop_front();
            if (codeB !== exp) begin
               errors++;
               $display("[TB] FAIL codeB: actual=%0d required=%0d", codeB, exp);
            end
         end
      end
   endtask

   // Drive one beat for one cycle; expA/expB are the expected codes, -1 for none
   task automatic applyStimulus(input logic [31:0] d, input logic last, input logic fa,
                                input int expA, input int expB);
      stepCycle();
      tvalid   = 1'b1;
      tdata    = d;
      tlast    = last;
      faStrobe = fa;
      if (expA >= 0) qA.push_back(expA[1:0]);
      if (expB >= 0) qB.push_back(expB[1:0]);
   endtask

   task automatic sendPacket(input logic [4:0] idx, input logic [7:0] cnt, input logic fa,
                             input int expA, input int expB);
      applyStimulus(hdr(idx), 1'b0, 1'b0, -1, -1);
      applyStimulus(dat(idx, cnt), 1'b1, fa, expA, expB);
   endtask

   task automatic idle(input int n);
      stepCycle();
      tvalid   = 1'b0;
      tlast    = 1'b0;
      faStrobe = 1'b0;
      for (int i = 1; i < n; i++) stepCycle();
   endtask

   task automatic pulseFa();
      stepCycle();
      tvalid   = 1'b0;
      tlast    = 1'b0;
      faStrobe = 1'b1;
      stepCycle();
      faStrobe = 1'b0;
   endtask

   // Let outstanding reports arrive, then require that none are still owed
   task automatic finishScoreboard(input string name);
      idle(4);
      checks++;
      if (qA.size() != 0 || qB.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s missing strobes: actual pendingA=%0d pendingB=%0d required=0", name, qA.size(), qB.size());
      end
      qA.delete();
      qB.delete();
   endtask

   task automatic applyReset();
      tvalid   = 1'b0;
      tlast    = 1'b0;
      faStrobe = 1'b0;
      resetN   = 1'b0;
      stepCycle();
      stepCycle();
      resetN = 1'b1;
      stepCycle();
   endtask

   task automatic test_reset();
      tvalid   = 1'b0;
      tlast    = 1'b0;
      faStrobe = 1'b0;
      tdata    = 32'd0;
      resetN   = 1'b0;
      stepCycle();
      stepCycle();
      checks++; if (treadyA !== 1'b0 || treadyB !== 1'b0) begin errors++; $display("[TB] FAIL reset tready: actual=%b/%b required=0", treadyA, treadyB); end
      checks++; if (strobeA !== 1'b0 || codeA !== 2'd0) begin errors++; $display("[TB] FAIL reset status: actual strobe=%b code=%0d required 0/0", strobeA, codeA); end
      checks++; if (lastIndexA !== 5'd0 || lastCycleA !== 8'd0) begin errors++; $display("[TB] FAIL reset last: actual idx=%0d cnt=%0d required 0/0", lastIndexA, lastCycleA); end
      checks++; if (packetCountA !== 16'd0 || errorCountA !== 16'd0) begin errors++; $display("[TB] FAIL reset counters: actual pkt=%0d err=%0d required 0/0", packetCountA, errorCountA); end
      resetN = 1'b1;
      stepCycle();
      checks++; if (treadyA !== 1'b1 || treadyB !== 1'b1) begin errors++; $display("[TB] FAIL release tready: actual=%b/%b required=1", treadyA, treadyB); end
   endtask

   task automatic test_basic();
      applyReset();
      applyStimulus(32'hB6CF_8C00, 1'b0, 1'b0, -1, -1);
      applyStimulus(32'h03CA_CA05, 1'b1, 1'b0, 0, 0);
      pulseFa();
      applyStimulus(32'hB6CF_8C00, 1'b0, 1'b0, -1, -1);
      applyStimulus(32'h03CA_CA06, 1'b1, 1'b0, 0, 0);
      finishScoreboard("basic");
      checks++; if (packetCountA !== 16'd2 || packetCountB !== 16'd2) begin errors++; $display("[TB] FAIL basic packetCount: actual=%0d/%0d required=2", packetCountA, packetCountB); end
      checks++; if (lastIndexA !== 5'd3 || lastIndexB !== 5'd3) begin errors++; $display("[TB] FAIL basic lastIndex: actual=%0d/%0d required=3", lastIndexA, lastIndexB); end
      checks++; if (lastCycleA !== 8'd6 || lastCycleB !== 8'd6) begin errors++; $display("[TB] FAIL basic lastCycleCount: actual=%0d/%0d required=6", lastCycleA, lastCycleB); end
      checks++; if (errorCountA !== 16'd0) begin errors++; $display("[TB] FAIL basic errorCount: actual=%0d required=0", errorCountA); end
   endtask

   task automatic test_bad_header();
      applyReset();
      applyStimulus(32'hB6CE_8C00, 1'b0, 1'b0, 1, 1);
      applyStimulus(32'h03CA_CA05, 1'b1, 1'b0, -1, -1);
      finishScoreboard("bad_header");
      checks++; if (errorCountA !== 16'd1 || packetCountA !== 16'd0) begin errors++; $display("[TB] FAIL bad_header counters: actual err=%0d pkt=%0d required 1/0", errorCountA, packetCountA); end
      sendPacket(5'd3, 8'h05, 1'b0, 0, 0);
      finishScoreboard("bad_header_recover");
      checks++; if (packetCountA !== 16'd1) begin errors++; $display("[TB] FAIL bad_header recover packetCount: actual=%0d required=1", packetCountA); end
   endtask

   task automatic test_framing();
      applyReset();
      applyStimulus(hdr(5'd3), 1'b0, 1'b0, -1, -1);
      applyStimulus(dat(5'd3, 8'h05), 1'b0, 1'b0, 3, 3);
      applyStimulus(dat(5'd3, 8'h05), 1'b1, 1'b0, -1, -1);
      applyStimulus(hdr(5'd3), 1'b1, 1'b0, 3, 3);
      sendPacket(5'd3, 8'h05, 1'b0, 0, 0);
      finishScoreboard("framing");
      checks++; if (errorCountA !== 16'd2 || packetCountA !== 16'd1) begin errors++; $display("[TB] FAIL framing counters: actual err=%0d pkt=%0d required 2/1", errorCountA, packetCountA); end
   endtask

   task automatic test_bad_data();
      applyReset();
      applyStimulus(32'hB6CF_8C00, 1'b0, 1'b0, -1, -1);
      applyStimulus(32'h04CA_CA05, 1'b1, 1'b0, 2, 2);
      applyStimulus(32'hB6CF_8C00, 1'b0, 1'b0, -1, -1);
      applyStimulus(32'h03CA_CB05, 1'b1, 1'b0, 2, 2);
      finishScoreboard("bad_data");
      checks++; if (codeA !== 2'd2 || strobeA !== 1'b0) begin errors++; $display("[TB] FAIL bad_data code hold: actual code=%0d strobe=%b required 2/0", codeA, strobeA); end
      checks++; if (errorCountA !== 16'd2 || packetCountA !== 16'd0) begin errors++; $display("[TB] FAIL bad_data counters: actual err=%0d pkt=%0d required 2/0", errorCountA, packetCountA); end
      sendPacket(5'd3, 8'h05, 1'b0, 0, 0);
      finishScoreboard("bad_data_recover");
      checks++; if (packetCountA !== 16'd1) begin errors++; $display("[TB] FAIL bad_data recover packetCount: actual=%0d required=1", packetCountA); end
   endtask

   task automatic test_counter_wrap();
      applyReset();
      sendPacket(5'd3, 8'hFF, 1'b1, 0, 0);
      pulseFa();
      sendPacket(5'd3, 8'h00, 1'b0, 0, 0);
      pulseFa();
      sendPacket(5'd3, 8'h02, 1'b0, 2, 2);
      sendPacket(5'd3, 8'h02, 1'b1, 0, 0);
      sendPacket(5'd3, 8'h03, 1'b0, 0, 0);
      finishScoreboard("counter_wrap");
      checks++; if (packetCountA !== 16'd4 || errorCountA !== 16'd1) begin errors++; $display("[TB] FAIL counter_wrap counters: actual pkt=%0d err=%0d required 4/1", packetCountA, errorCountA); end
      checks++; if (lastCycleA !== 8'h03 || lastCycleB !== 8'h03) begin errors++; $display("[TB] FAIL counter_wrap lastCycleCount: actual=%0d/%0d required=3", lastCycleA, lastCycleB); end
   endtask

   task automatic test_mult_pack();
      applyReset();
      sendPacket(5'd31, 8'h07, 1'b0, 0, 0);
      sendPacket(5'd0, 8'h07, 1'b0, 0, 0);
      sendPacket(5'd1, 8'h07, 1'b0, 0, 0);
      pulseFa();
      sendPacket(5'd31, 8'h08, 1'b0, 0, 0);
      sendPacket(5'd2, 8'h08, 1'b0, 0, 2);
      finishScoreboard("mult_pack");
      checks++; if (packetCountA !== 16'd5 || lastIndexA !== 5'd2) begin errors++; $display("[TB] FAIL mult_pack dutA: actual pkt=%0d idx=%0d required 5/2", packetCountA, lastIndexA); end
      checks++; if (packetCountB !== 16'd4 || lastIndexB !== 5'd31 || errorCountB !== 16'd1) begin errors++; $display("[TB] FAIL mult_pack dutB: actual pkt=%0d idx=%0d err=%0d required 4/31/1", packetCountB, lastIndexB, errorCountB); end
   endtask

   task automatic test_back_to_back();
      applyReset();
      for (int i = 0; i < 4; i++) sendPacket(5'(i), 8'h09, 1'b0, 0, 0);
      finishScoreboard("back_to_back");
      checks++; if (packetCountA !== 16'd4 || packetCountB !== 16'd4) begin errors++; $display("[TB] FAIL back_to_back packetCount: actual=%0d/%0d required=4", packetCountA, packetCountB); end
   endtask

   task automatic test_reset_mid_packet();
      applyReset();
      sendPacket(5'd5, 8'h01, 1'b0, 0, 0);
      finishScoreboard("pre_reset");
      applyStimulus(hdr(5'd3), 1'b0, 1'b0, -1, -1);
      stepCycle();
      tvalid = 1'b0;
      tlast  = 1'b0;
      resetN = 1'b0;
      #1;
      checks++; if (packetCountA !== 16'd0 || lastIndexA !== 5'd0 || treadyA !== 1'b0) begin errors++; $display("[TB] FAIL async reset: actual pkt=%0d idx=%0d ready=%b required 0/0/0", packetCountA, lastIndexA, treadyA); end
      stepCycle();
      resetN = 1'b1;
      stepCycle();
      sendPacket(5'd3, 8'h05, 1'b0, 0, 0);
      finishScoreboard("reset_mid_packet");
      checks++; if (packetCountA !== 16'd1 || lastIndexA !== 5'd3 || errorCountA !== 16'd0) begin errors++; $display("[TB] FAIL reset_mid_packet: actual pkt=%0d idx=%0d err=%0d required 1/3/0", packetCountA, lastIndexA, errorCountA); end
   endtask

   // Scenario sequence
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_bad_header();
      test_framing();
      test_bad_data();
      test_counter_wrap();
      test_mult_pack();
      test_back_to_back();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
